// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH -> DECODE -> EXECUTE -> [MEM] -> WB,
// with a sticky TRAP state for illegal opcodes and memory handshake timeouts.
module core_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] i_opcode,
    input  logic       i_branch_taken,
    output logic       o_im_req,
    input  logic       i_im_ready,
    output logic       o_dm_req,
    output logic       o_dm_we,
    input  logic       i_dm_ready,
    output logic       o_ir_we,
    output logic       o_rf_we,
    output logic       o_pc_we,
    output logic [1:0] o_pc_sel,
    output logic [1:0] o_wb_sel,
    output logic       o_retire,
    output logic       o_illegal,
    output logic       o_bus_err
);

    // Handshake: a request (o_im_req / o_dm_req) stays high for every cycle the
    // sequencer sits in FETCH / MEM; the access completes in the cycle the matching
    // ready is high, and ready is ignored in every other state.

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_NONE    = 4'd0,
        C_RINT    = 4'd1,
        C_IINT    = 4'd2,
        C_ILOAD   = 4'd3,
        C_IJUMP   = 4'd4,
        C_SBRANCH = 4'd5,
        C_SSTORE  = 4'd6,
        C_UIMM    = 4'd7,
        C_UPC     = 4'd8,
        C_UJUMP   = 4'd9
    } cls_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d;
    logic       taken_q, taken_d;
    logic [7:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       bus_err_q, bus_err_d;

    cls_t       dec_cls;
    logic [7:0] wait_inc;
    logic       timed_out;

    function automatic cls_t decode_class(input logic [6:0] op);
        case (op)
            7'b0110011: decode_class = C_RINT;
            7'b0010011: decode_class = C_IINT;
            7'b0000011: decode_class = C_ILOAD;
            7'b1100111: decode_class = C_IJUMP;
            7'b1100011: decode_class = C_SBRANCH;
            7'b0100011: decode_class = C_SSTORE;
            7'b0110111: decode_class = C_UIMM;
            7'b0010111: decode_class = C_UPC;
            7'b1101111: decode_class = C_UJUMP;
            default:    decode_class = C_NONE;
        endcase
    endfunction

    // Next-state logic; the wait counter saturates so it can never wrap to zero.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        taken_d   = taken_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        dec_cls   = decode_class(i_opcode);
        wait_inc  = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
        timed_out = (wait_q >= TIMEOUT_LIMIT);

        case (state_q)
            S_FETCH: begin
                if (i_im_ready) begin
                    state_d = S_DECODE;
                    wait_d  = 8'd0;
                end else if (timed_out) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                if (dec_cls == C_NONE) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                taken_d = i_branch_taken;
                if (cls_q == C_ILOAD || cls_q == C_SSTORE) begin
                    state_d = S_MEM;
                    wait_d  = 8'd0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (i_dm_ready) begin
                    state_d = S_WB;
                end else if (timed_out) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                wait_d  = 8'd0;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cls_q     <= C_NONE;
            taken_q   <= 1'b0;
            wait_q    <= 8'd0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            taken_q   <= taken_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Outputs decode straight from state so that an asserted rst silences them
    // at once, even mid-access.
    always_comb begin
        o_im_req  = 1'b0;
        o_ir_we   = 1'b0;
        o_dm_req  = 1'b0;
        o_dm_we   = 1'b0;
        o_rf_we   = 1'b0;
        o_pc_we   = 1'b0;
        o_pc_sel  = 2'd0;
        o_wb_sel  = 2'd0;
        o_retire  = 1'b0;
        o_illegal = 1'b0;
        o_bus_err = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    o_im_req = 1'b1;
                    o_ir_we  = i_im_ready;
                end
                S_MEM: begin
                    o_dm_req = 1'b1;
                    o_dm_we  = (cls_q == C_SSTORE);
                end
                S_WB: begin
                    o_pc_we  = 1'b1;
                    o_retire = 1'b1;
                    o_rf_we  = !(cls_q == C_SBRANCH || cls_q == C_SSTORE);
                    case (cls_q)
                        C_UJUMP:   o_pc_sel = 2'd1;
                        C_SBRANCH: o_pc_sel = taken_q ? 2'd1 : 2'd0;
                        C_IJUMP:   o_pc_sel = 2'd2;
                        default:   o_pc_sel = 2'd0;
                    endcase
                    case (cls_q)
                        C_ILOAD:         o_wb_sel = 2'd1;
                        C_UJUMP, C_IJUMP: o_wb_sel = 2'd2;
                        C_UIMM:          o_wb_sel = 2'd3;
                        default:         o_wb_sel = 2'd0;
                    endcase
                end
                S_TRAP: begin
                    o_illegal = illegal_q;
                    o_bus_err = bus_err_q;
                end
                default: ;
            endcase
        end
    end

endmodule
